// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: FSM encoding and
// the default byte address of RAM word 0.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto one synchronous single-port RAM port.
// Each access is IDLE -> ACCESS -> DONE, ack two cycles after the request.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(BASE_ADDR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    arb_state_t            state, state_next;
    logic                  last_grant;
    logic [1:0]            grant;
    logic                  lat_winner;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_err;
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] word_index;
    logic                  addr_valid;

    rr_arbiter_2 u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Decoded from the latched address, so it is stable throughout ACCESS.
    assign offset     = lat_addr - BASE_ADDR;
    assign word_index = offset >> 2;
    assign addr_valid = (lat_addr >= BASE_ADDR) && (lat_addr[1:0] == 2'b00)
                        && (word_index < DATA_WIDTH'(MEMORY_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_winner <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_err    <= 1'b0;
        end else begin
            if (state == IDLE && grant != 2'b00) begin
                last_grant <= grant[1];
                lat_winner <= grant[1];
                lat_we     <= grant[1] ? m1_we    : m0_we;
                lat_addr   <= grant[1] ? m1_addr  : m0_addr;
                lat_wdata  <= grant[1] ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS) begin
                lat_err <= !addr_valid;
            end
        end
    end

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        m0_ack     = 1'b0;
        m0_err     = 1'b0;
        m0_rdata   = '0;
        m1_ack     = 1'b0;
        m1_err     = 1'b0;
        m1_rdata   = '0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = DONE;
                if (addr_valid) begin
                    ram_we    = lat_we;
                    ram_addr  = word_index;
                    ram_wdata = lat_wdata;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (lat_winner) begin
                    m1_ack   = 1'b1;
                    m1_err   = lat_err;
                    m1_rdata = (!lat_we && !lat_err) ? ram_rdata : '0;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = lat_err;
                    m0_rdata = (!lat_we && !lat_err) ? ram_rdata : '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural synchronous RAM.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem [32];
    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        no_we_window = 1'b0;

    ram_port_arbiter #(.MEMORY_DEPTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h1001_0000)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-before-write synchronous RAM model
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr[4:0]];
        if (ram_we) mem[ram_addr[4:0]] <= ram_wdata;
    end

    always @(negedge clk) begin
        exp_t  e;
        logic  p;
        if (m0_ack || m1_ack) begin
            total++;
            if (m0_ack && m1_ack) begin
                bad++;
                $display("FAIL both_ack cyc=%0d got m0_ack=1 m1_ack=1 want at most one", cyc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack cyc=%0d got m0_ack=%0b m1_ack=%0b want none", cyc, m0_ack, m1_ack);
            end else begin
                e = sb.pop_front();
                p = m1_ack;
                if (p !== e.port || (p ? m1_err : m0_err) !== e.err
                    || (p ? m1_rdata : m0_rdata) !== e.rdata || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL ack_check got port=%0d err=%0b rdata=%h cyc=%0d want port=%0d err=%0b rdata=%h cyc=%0d",
                             p, p ? m1_err : m0_err, p ? m1_rdata : m0_rdata, cyc,
                             e.port, e.err, e.rdata, e.cyc);
                end
            end
        end
        if (no_we_window) begin
            total++;
            if (ram_we !== 1'b0) begin
                bad++;
                $display("FAIL ram_we_invalid cyc=%0d got ram_we=%0b want 0", cyc, ram_we);
            end
        end
    end

    task automatic push_exp(input logic port, input logic err, input logic [31:0] rdata, input int at);
        exp_t e;
        e.port = port; e.err = err; e.rdata = rdata; e.cyc = at;
        sb.push_back(e);
    endtask

    // One-cycle request pulse, then wait for the access to finish.
    task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        push_exp(port, exp_err, exp_rdata, cyc + 2);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + i;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        total++;
        if ({m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, ram_we, ram_addr, ram_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got nonzero outputs want all zero");
        end

        // Both requesters hold req: grants alternate m0, m1, m0, m1
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0004;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1001_0008;
        push_exp(1'b0, 1'b0, 32'hC0DE_0001, cyc + 2);
        push_exp(1'b1, 1'b0, 32'hC0DE_0002, cyc + 5);
        push_exp(1'b0, 1'b0, 32'hC0DE_0001, cyc + 8);
        push_exp(1'b1, 1'b0, 32'hC0DE_0002, cyc + 11);
        repeat (11) @(posedge clk);
        #1 m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(posedge clk);

        issue(1'b0, 1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'hFFFF_FFFF);

        no_we_window = 1'b1;
        issue(1'b0, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 1'b1, 32'h1001_000E, 32'h5555_5555, 1'b1, 32'h0);
        issue(1'b0, 1'b1, 32'h1001_0080, 32'h6666_6666, 1'b1, 32'h0);
        @(posedge clk); #1 no_we_window = 1'b0;

        issue(1'b1, 1'b1, 32'h1001_007C, 32'hA0A0_A0A0, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 32'h1001_007C, 32'h0, 1'b0, 32'hA0A0_A0A0);
        issue(1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'hFFFF_FFFF);

        // Single-cycle pulse: exactly one ack, then silence
        issue(1'b0, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'hC0DE_0002);
        repeat (5) @(posedge clk);

        // Reset during ACCESS drops the read; next request completes normally
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0004;
        @(posedge clk); #1;
        m0_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({m0_ack, m1_ack, ram_we, ram_addr} !== '0) begin
            bad++;
            $display("FAIL reset_in_access got ack/ram activity want idle outputs");
        end
        repeat (3) @(posedge clk);
        issue(1'b1, 1'b0, 32'h1001_007C, 32'h0, 1'b0, 32'hA0A0_A0A0);
        repeat (4) @(posedge clk);

        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_acks got pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32, number of words in the shared RAM.
REQ-002 Parameter DATA_WIDTH, default 32, width of data and byte addresses.
REQ-003 Parameter BASE_ADDR, default 32'h10010000, byte address mapped to RAM word 0.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 m0_req / m1_req  in  1  access request from requester 0 / 1.
REQ-008 m0_we / m1_we  in  1  1 = write, 0 = read.
REQ-009 m0_addr / m1_addr  in  DATA_WIDTH  byte address.
REQ-010 m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
REQ-011 m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-012 m0_err / m1_err  out  1  qualifies ack: address invalid, no RAM access made.
REQ-013 m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid only while ack=1 and err=0, else zero.
REQ-014 ram_we  out  1  write enable to single_port_sync_ram.
REQ-015 ram_addr  out  DATA_WIDTH  word index to RAM.
REQ-016 ram_wdata  out  DATA_WIDTH  write data to RAM.
REQ-017 ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the address edge.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, DONE; each non-IDLE state lasts exactly one cycle.
REQ-019 IDLE with any req=1 in cycle N: latch winner index, we, addr, wdata; go ACCESS in N+1; else stay IDLE.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; single request wins unconditionally.
REQ-021 last_grant SHALL update only on a grant; reset value 1 so requester 0 wins the first tie.
REQ-022 Word index = (addr - BASE_ADDR) >> 2; valid iff addr >= BASE_ADDR, addr[1:0]=0, index < MEMORY_DEPTH.
REQ-023 ACCESS (N+1), valid address: drive ram_addr=index, ram_wdata=latched wdata, ram_we=latched we; ram_we SHALL be high in no other cycle.
REQ-024 ACCESS, invalid address: ram_we=0, error flag latched.
REQ-025 DONE (N+2): winner ack=1 for exactly one cycle, err=latched flag; on read, rdata=ram_rdata; loser ack=0; next state IDLE.
REQ-026 Fixed latency request-to-ack = 2 cycles; throughput one access per 3 cycles.
REQ-027 Requests arriving during ACCESS/DONE SHALL be held by the requester and arbitrated in the next IDLE.
REQ-028 Requester dropping req after latch SHALL NOT cancel the access; ack still issued.
REQ-029 Requester holding req through ack SHALL be treated as a new request in the following IDLE.
REQ-030 ram_addr/ram_wdata SHALL be zero outside ACCESS.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, last_grant=1, all latches zero; from the next cycle all outputs are zero.
REQ-032 Reset in ACCESS or DONE SHALL drop the in-flight access with no ack; a write already committed in ACCESS is not undone.

Structure
REQ-033 State encoding and BASE_ADDR default SHALL live in a shared package used by controller and benches.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter_2 (req[1:0], last_grant -> grant one-hot).
REQ-035 single_port_sync_ram SHALL be instantiated outside this block; only its port is driven.

Verification
REQ-036 m0 write addr 32'h10010000 data 32'hFFFFFFFF, then m1 read same addr -> m1 ack at request+2 with rdata 32'hFFFFFFFF, err=0.
REQ-037 m0 and m1 req same cycle after reset, repeated 4 times -> grants m0,m1,m0,m1; never both ack in one cycle.
REQ-038 Read addr 32'h12345678 / 32'h1001000E / 32'h10010080 (depth 32) -> ack with err=1, ram_we never high.
REQ-039 Write index 31 (32'h1001007C) data 32'hA0A0A0A0, read back -> 32'hA0A0A0A0; index 0 contents unchanged.
REQ-040 rst asserted during ACCESS of a read -> no ack, state IDLE next cycle, subsequent m1 request completes normally at +2.
REQ-041 m0_req pulsed one cycle only -> access completes, single ack, no repeat access.
